// File: rtl/ccff_loader_pkg.sv
// Shared types and defaults for the configuration-chain loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } ccff_state_e;

    localparam int CCFF_WORD_W_DEF    = 8;
    localparam int CCFF_CHAIN_LEN_DEF = 18;

endpackage

// File: rtl/ccff_loader_if.sv
// Bitstream handshake, chain-side serial pins and readback strobe of the loader.
interface ccff_loader_if #(
    parameter int WORD_W = ccff_loader_pkg::CCFF_WORD_W_DEF
);
    import ccff_loader_pkg::*;

    logic              start;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              ccff_head;
    logic              ccff_tail;
    logic              chain_clk_en;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] rb_data;
    logic              rb_valid;

    modport master (
        output start, cfg_data, cfg_valid, ccff_tail,
        input  cfg_ready, ccff_head, chain_clk_en, busy, done, rb_data, rb_valid
    );

    modport slave (
        input  start, cfg_data, cfg_valid, ccff_tail,
        output cfg_ready, ccff_head, chain_clk_en, busy, done, rb_data, rb_valid
    );

endinterface

// File: rtl/ccff_rb_packer.sv
// Packs the bits returning from the chain tail into MSB-first words; a final
// partial word is left-aligned and zero-padded.
module ccff_rb_packer
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W = CCFF_WORD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              cap_i,
    input  logic              last_i,
    input  logic              tail_i,
    output logic [WORD_W-1:0] rb_data_o,
    output logic              rb_valid_o
);
    localparam int BW = $clog2(WORD_W);
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);

    logic [WORD_W-2:0] pack_q;
    logic [BW-1:0]     bit_cnt_q;
    logic [WORD_W-1:0] word;
    logic [BW-1:0]     pad;
    logic              full;

    // pad is zero for a full word, so one shift covers both emit cases
    always_comb begin
        word = {pack_q, tail_i};
        full = (bit_cnt_q == BIT_LAST);
        pad  = BIT_LAST - bit_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_q     <= '0;
            bit_cnt_q  <= '0;
            rb_data_o  <= '0;
            rb_valid_o <= 1'b0;
        end else begin
            rb_valid_o <= 1'b0;
            if (clear_i) begin
                pack_q    <= '0;
                bit_cnt_q <= '0;
            end else if (cap_i) begin
                if (full || last_i) begin
                    rb_data_o  <= word << pad;
                    rb_valid_o <= 1'b1;
                    pack_q     <= '0;
                    bit_cnt_q  <= '0;
                end else begin
                    pack_q    <= word[WORD_W-2:0];
                    bit_cnt_q <= bit_cnt_q + BW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ccff_loader.sv
// Serializes bitstream words MSB-first onto ccff_head with a registered ICG enable.
// Optional chain readback through ccff_tail is built when CCFF_READBACK_EN is defined.
module ccff_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = CCFF_CHAIN_LEN_DEF,
    parameter int WORD_W    = CCFF_WORD_W_DEF
) (
    input  logic         prog_clk,
    input  logic         pReset,
    ccff_loader_if.slave bus
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int IW = $clog2(WORD_W);
    localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_LEN - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WORD_W - 1);

    ccff_state_e       state_q;
    logic [CW-1:0]     cnt_q;
    logic [IW-1:0]     idx_q;
    logic [WORD_W-1:0] sreg_q;
    logic              cfg_ready_q;
    logic              head_q;
    logic              clk_en_q;
    logic              busy_q;
    logic              done_q;

    logic              start_ok;
    logic              in_shift;
    logic              last_bit;

    assign start_ok = bus.start && ((state_q == IDLE) || (state_q == DONE));
    assign in_shift = (state_q == SHIFT);
    assign last_bit = in_shift && (cnt_q == CNT_LAST);

    // sreg_q holds the bits not yet presented; head_q is the bit on the wire now
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            sreg_q      <= '0;
            cfg_ready_q <= 1'b0;
            head_q      <= 1'b0;
            clk_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q     <= FETCH;
                        cnt_q       <= '0;
                        done_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        cfg_ready_q <= 1'b1;
                    end
                end
                FETCH: begin
                    if (bus.cfg_valid && cfg_ready_q) begin
                        state_q     <= SHIFT;
                        cfg_ready_q <= 1'b0;
                        head_q      <= bus.cfg_data[WORD_W-1];
                        sreg_q      <= {bus.cfg_data[WORD_W-2:0], 1'b0};
                        clk_en_q    <= 1'b1;
                        idx_q       <= '0;
                    end
                end
                SHIFT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        clk_en_q <= 1'b0;
                        head_q   <= 1'b0;
                    end else if (idx_q == IDX_LAST) begin
                        state_q     <= FETCH;
                        cfg_ready_q <= 1'b1;
                        clk_en_q    <= 1'b0;
                        head_q      <= 1'b0;
                    end else begin
                        head_q <= sreg_q[WORD_W-1];
                        sreg_q <= {sreg_q[WORD_W-2:0], 1'b0};
                        idx_q  <= idx_q + IW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cfg_ready    = cfg_ready_q;
    assign bus.ccff_head    = head_q;
    assign bus.chain_clk_en = clk_en_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0] rb_data;
    logic              rb_valid;

    ccff_rb_packer #(
        .WORD_W (WORD_W)
    ) u_rb_packer (
        .clk        (prog_clk),
        .rst        (pReset),
        .clear_i    (start_ok),
        .cap_i      (in_shift),
        .last_i     (last_bit),
        .tail_i     (bus.ccff_tail),
        .rb_data_o  (rb_data),
        .rb_valid_o (rb_valid)
    );

    assign bus.rb_data  = rb_data;
    assign bus.rb_valid = rb_valid;
`else
    logic unused_rb;
    assign unused_rb    = start_ok ^ last_bit;
    assign bus.rb_data  = '0;
    assign bus.rb_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader: CHAIN_LEN=18, WORD_W=8, with a gated-clock chain model.
module tb_ccff_loader;
    import ccff_loader_pkg::*;

    localparam logic [17:0] PATTERN = 18'b101001010011110011;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ccff_loader_if #(.WORD_W(8)) bus ();

    ccff_loader #(
        .CHAIN_LEN (18),
        .WORD_W    (8)
    ) dut (
        .prog_clk (clk),
        .pReset   (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // chain model shifts on the gated edge that follows an enabled cycle
    logic [17:0] chain = '0;
    logic [31:0] hlog = '0;
    int en_cnt = 0;
    int busy_cnt = 0;
    logic [7:0] rb_q[$];

    assign bus.ccff_tail = chain[17];

    always @(posedge clk) begin
        if (bus.chain_clk_en) begin
            chain  <= {chain[16:0], bus.ccff_head};
            hlog   <= {hlog[30:0], bus.ccff_head};
            en_cnt <= en_cnt + 1;
        end
        if (bus.busy) busy_cnt <= busy_cnt + 1;
        if (bus.rb_valid) rb_q.push_back(bus.rb_data);
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs_vec();
        return {19'd0, bus.cfg_ready, bus.ccff_head, bus.chain_clk_en,
                bus.busy, bus.done, bus.rb_valid, bus.rb_data};
    endfunction

    task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                            input int stall_word, input bit glitch, input bit chk_rb,
                            input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2);
        logic [7:0] words [3];
        int e0, b0, q0, s0, exp_busy;
        bit ok;
        words[0] = w0;
        words[1] = w1;
        words[2] = w2;
        exp_busy = 21 + ((stall_word >= 0 && stall_word < 3) ? 5 : 0);
        e0 = en_cnt;
        b0 = busy_cnt;
        q0 = rb_q.size();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_ready", bus.cfg_ready, 1);
        chk("start_busy", bus.busy, 1);
        chk("start_done", bus.done, 0);
        for (int i = 0; i < 3; i++) begin
            if (i == stall_word) begin
                ok = 1'b0;
                for (int k = 0; k < 64 && !ok; k++) begin
                    if (bus.cfg_ready) ok = 1'b1;
                    else @(negedge clk);
                end
                chk("stall_reach", ok, 1);
                s0 = en_cnt;
                repeat (5) begin
                    chk("stall_en", bus.chain_clk_en, 0);
                    @(negedge clk);
                end
                chk("stall_frozen", en_cnt, s0);
                chk("stall_ready", bus.cfg_ready, 1);
            end
            bus.cfg_valid = 1'b1;
            bus.cfg_data  = words[i];
            ok = 1'b0;
            for (int k = 0; k < 64 && !ok; k++) begin
                ok = bus.cfg_ready;
                @(negedge clk);
            end
            bus.cfg_valid = 1'b0;
            chk("accept", ok, 1);
            if (glitch && i == 0) begin
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
                chk("glitch_busy", bus.busy, 1);
                chk("glitch_en", bus.chain_clk_en, 1);
            end
        end
        ok = 1'b0;
        for (int k = 0; k < 64 && !ok; k++) begin
            if (bus.done) ok = 1'b1;
            else @(negedge clk);
        end
        chk("done_reach", ok, 1);
        chk("done_busy", bus.busy, 0);
        chk("done_en", bus.chain_clk_en, 0);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 8'h00;
        repeat (3) begin
            @(negedge clk);
            chk("done_hold", bus.done, 1);
            chk("done_ready", bus.cfg_ready, 0);
        end
        bus.cfg_valid = 1'b0;
        chk("en_cycles", en_cnt - e0, 18);
        chk("busy_cycles", busy_cnt - b0, exp_busy);
        chk("head_seq", hlog[17:0], PATTERN);
        chk("chain", chain, PATTERN);
`ifdef CCFF_READBACK_EN
        if (chk_rb) begin
            chk("rb_count", rb_q.size() - q0, 3);
            if (rb_q.size() >= q0 + 3) begin
                chk("rb0", rb_q[q0], r0);
                chk("rb1", rb_q[q0+1], r1);
                chk("rb2", rb_q[q0+2], r2);
            end
        end
`else
        chk("rb_none", rb_q.size(), 0);
        chk("rb_data_tied", bus.rb_data, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        bit ok;
        bus.start     = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 8'hA5;

        // reset held 3 cycles with start asserted
        repeat (3) @(negedge clk);
        chk("rst_outs", outs_vec(), 0);
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.cfg_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_outs", outs_vec(), 0);

        // first pass reads back the empty chain, second pass the loaded pattern
        run_load(8'hA5, 8'h3C, 8'hFF, -1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        run_load(8'hA5, 8'h3C, 8'hFF, 1, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'hC0);
        run_load(8'hA5, 8'h3C, 8'hFF, -1, 1'b1, 1'b1, 8'hA5, 8'h3C, 8'hC0);

        // reset in the middle of a load
        bus.start = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        e0            = en_cnt;
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 8'h5A;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            if (en_cnt - e0 == 10) ok = 1'b1;
            else @(negedge clk);
        end
        chk("abort_reach", ok, 1);
        chk("abort_en_live", bus.chain_clk_en, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outs", outs_vec(), 0);
        rst           = 1'b0;
        bus.cfg_valid = 1'b0;
        @(negedge clk);
        chk("abort_idle", outs_vec(), 0);

        run_load(8'hA5, 8'h3C, 8'hFF, -1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
